// File: rtl/prime_rf_arbiter_if.sv
// Host write, two-reader arbitration, response and register-file signals
// of the prime register-file arbiter.
interface prime_rf_arbiter_if #(
    parameter int XLEN    = 33,
    parameter int AR_BITS = 6
);
    logic                          wr_valid;
    logic                          wr_ready;
    logic [AR_BITS-1:0]            wr_adr;
    logic [XLEN-1:0]               wr_data;
    logic                          rd0_req;
    logic [AR_BITS-1:0]            rd0_adr;
    logic                          rd0_gnt;
    logic                          rd1_req;
    logic [AR_BITS-1:0]            rd1_adr;
    logic                          rd1_gnt;
    logic                          rsp_valid;
    logic                          rsp_id;
    logic [XLEN-1:0]               rsp_data0;
    logic [XLEN-1:0]               rsp_data1;
    logic                          rsp_err;
    logic                          init_done;
    logic [AR_BITS-1:0]            rf_adr;
    logic [1:0][XLEN-1:0]          rf_src;
    logic [AR_BITS-1:0]            rf_dst;
    logic [XLEN-1:0]               rf_dstw;

    modport slave (
        input  wr_valid, wr_adr, wr_data,
        input  rd0_req, rd0_adr, rd1_req, rd1_adr,
        input  rf_src,
        output wr_ready, rd0_gnt, rd1_gnt,
        output rsp_valid, rsp_id, rsp_data0, rsp_data1, rsp_err,
        output init_done, rf_adr, rf_dst, rf_dstw
    );

    modport master (
        output wr_valid, wr_adr, wr_data,
        output rd0_req, rd0_adr, rd1_req, rd1_adr,
        output rf_src,
        input  wr_ready, rd0_gnt, rd1_gnt,
        input  rsp_valid, rsp_id, rsp_data0, rsp_data1, rsp_err,
        input  init_done, rf_adr, rf_dst, rf_dstw
    );
endinterface

// File: rtl/prime_rf_arbiter.sv
// Clears the register file after reset, then arbitrates two pair-readers
// round-robin around a single host write port.
//
// state | meaning
// INIT  | writing zero to every entry, counter walks 0..N-1
// RUN   | host writes accepted, readers arbitrated
module prime_rf_arbiter #(
    parameter int XLEN    = 33,
    parameter int AR_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    prime_rf_arbiter_if.slave bus
);
    localparam logic [AR_BITS-1:0] ADR_MAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, state_nxt;
    logic [AR_BITS-1:0] clr_cnt;
    logic [AR_BITS-1:0] last_adr;
    logic [XLEN-1:0]    last_data;
    logic               rr_ptr;
    logic               init_done_q;
    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic               rsp_err_q;
    logic               wr_acc;
    logic               elig0, elig1;
    logic               gnt0, gnt1;
    logic               wr_ready_c;
    logic [AR_BITS-1:0] rf_dst_c;
    logic [XLEN-1:0]    rf_dstw_c;
    logic [AR_BITS-1:0] rd0_nxt, rd1_nxt;

    assign rd0_nxt = bus.rd0_adr + AR_BITS'(1);
    assign rd1_nxt = bus.rd1_adr + AR_BITS'(1);
    assign wr_acc  = (state == RUN) && bus.wr_valid;

    // A reader whose pair overlaps this cycle's write would see stale data.
    assign elig0 = (state == RUN) && bus.rd0_req &&
                   !(wr_acc && (bus.wr_adr == bus.rd0_adr || bus.wr_adr == rd0_nxt));
    assign elig1 = (state == RUN) && bus.rd1_req &&
                   !(wr_acc && (bus.wr_adr == bus.rd1_adr || bus.wr_adr == rd1_nxt));

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (clr_cnt == ADR_MAX) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        wr_ready_c = 1'b0;
        rf_dst_c   = last_adr;
        rf_dstw_c  = last_data;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state)
            INIT: begin
                rf_dst_c  = clr_cnt;
                rf_dstw_c = '0;
            end
            RUN: begin
                wr_ready_c = 1'b1;
                if (bus.wr_valid) begin
                    rf_dst_c  = bus.wr_adr;
                    rf_dstw_c = bus.wr_data;
                end
                // rr_ptr high means rd1 wins a tie
                gnt0 = elig0 && (!elig1 || !rr_ptr);
                gnt1 = elig1 && (!elig0 || rr_ptr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt     <= '0;
            last_adr    <= '0;
            last_data   <= '0;
            rr_ptr      <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (state == INIT) begin
                clr_cnt   <= clr_cnt + AR_BITS'(1);
                last_adr  <= clr_cnt;
                last_data <= '0;
            end else if (wr_acc) begin
                last_adr  <= bus.wr_adr;
                last_data <= bus.wr_data;
            end
            if (gnt0 || gnt1) rr_ptr <= gnt0;
            init_done_q <= (state_nxt == RUN);
            rsp_valid_q <= gnt0 || gnt1;
            rsp_id_q    <= gnt1;
            rsp_err_q   <= (gnt0 || gnt1) && (bus.rf_adr == ADR_MAX);
        end
    end

    assign bus.wr_ready  = wr_ready_c;
    assign bus.rd0_gnt   = gnt0;
    assign bus.rd1_gnt   = gnt1;
    assign bus.rf_adr    = gnt1 ? bus.rd1_adr : bus.rd0_adr;
    assign bus.rf_dst    = rf_dst_c;
    assign bus.rf_dstw   = rf_dstw_c;
    assign bus.init_done = init_done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
    // Register-file data arrives registered, so the response reuses it directly.
    assign bus.rsp_data0 = rsp_valid_q ? bus.rf_src[0] : '0;
    assign bus.rsp_data1 = (rsp_valid_q && !rsp_err_q) ? bus.rf_src[1] : '0;
endmodule

// File: doc/prime_rf_arbiter.md
PRIME_RF_ARBITER -- requirements
Module: prime_rf_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 33, prime word width.
REQ-002 SHALL have parameter AR_BITS, default 6, register-file address width; depth N = 2**AR_BITS.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_valid  in  1  host write request.
REQ-006 SHALL have port wr_ready  out  1  host write accepted when high with wr_valid.
REQ-007 SHALL have port wr_adr  in  AR_BITS  host write address.
REQ-008 SHALL have port wr_data  in  XLEN  host write data.
REQ-009 SHALL have port rdK_req  in  1  read request from reader K (K = 0, 1).
REQ-010 SHALL have port rdK_adr  in  AR_BITS  pair base address for reader K.
REQ-011 SHALL have port rdK_gnt  out  1  reader K issued this cycle.
REQ-012 SHALL have port rsp_valid  out  1  response strobe.
REQ-013 SHALL have port rsp_id  out  1  reader index of the response.
REQ-014 SHALL have port rsp_data0, rsp_data1  out  XLEN each  entries adr and adr+1.
REQ-015 SHALL have port rsp_err  out  1  pair base was N-1.
REQ-016 SHALL have port init_done  out  1  clear sequence complete.
REQ-017 SHALL have port rf_adr  out  AR_BITS  register-file read address.
REQ-018 SHALL have port rf_src  in  2 x XLEN  registered register-file read data.
REQ-019 SHALL have ports rf_dst  out  AR_BITS and rf_dstw  out  XLEN  register-file write address and data (file writes every cycle).

Function
REQ-020 SHALL implement FSM states INIT and RUN; rst forces INIT with clear counter 0.
REQ-021 In INIT SHALL drive rf_dst = counter and rf_dstw = 0, incrementing each cycle.
REQ-022 SHALL go INIT->RUN after writing address N-1, i.e. N cycles after rst release; init_done is then registered high.
REQ-023 In INIT SHALL hold wr_ready, rd0_gnt, rd1_gnt and rsp_valid at 0.
REQ-024 In RUN SHALL drive wr_ready = 1 and on wr_valid drive rf_dst = wr_adr, rf_dstw = wr_data in the same cycle.
REQ-025 With no accepted write, SHALL re-drive the last written address and data; after INIT these are N-1 and 0.
REQ-026 SHALL allow at most one read grant per cycle; rf_adr = winner's rdK_adr, combinational in that cycle.
REQ-027 SHALL exclude a requester when an accepted write in the same cycle targets its adr or adr+1 (mod N).
REQ-028 Among eligible requesters SHALL grant round-robin: on contention, the one not granted last; pointer resets to favour rd0.
REQ-029 A lone eligible requester SHALL be granted without regard to the pointer.
REQ-030 SHALL assert rsp_valid exactly one cycle after a grant, with rsp_id = granted K, rsp_data0 = rf_src[0] and rsp_data1 = rf_src[1].
REQ-031 For a granted adr of N-1, SHALL force rsp_data1 = 0 and assert rsp_err with that response; otherwise rsp_err = 0.
REQ-032 A requester SHALL hold rdK_req and rdK_adr until its grant; unrequested and back-to-back grants are legal, one per cycle.

Reset
REQ-033 On rst SHALL clear init_done, rsp_valid, rsp_err, rsp_id, rsp_data0/1, grants and RR pointer to 0, and restart INIT, including when asserted mid-INIT or mid-RUN.
REQ-034 A response pending at rst SHALL be discarded.

Verification
REQ-035 Release rst, hold all requests -> init_done rises after exactly N=64 cycles; a read of any address then returns 0,0.
REQ-036 Write adr 5 = 0x1_0000_0001 and adr 6 = 7, then rd0 adr 5 -> rd0_gnt, next cycle rsp_valid, id 0, data 0x1_0000_0001 / 7.
REQ-037 rd0 and rd1 held continuously -> grants alternate rd0, rd1, rd0, ...; rsp_id follows one cycle later.
REQ-038 Write adr 10 while rd1 requests adr 9 and rd0 requests adr 20 -> rd0 granted; rd1 granted next cycle and reads the new value.
REQ-039 rd1 adr 63 -> rsp_err = 1, rsp_data1 = 0.
REQ-040 Assert rst at INIT count 30 -> counter restarts; init_done rises 64 cycles after release.
